// File: rtl/acm_in_feeder.sv
// -----------------------------------------------------------------------------
// acm_in_feeder
//
// User-side feeder for the mini-DMA external interface IN path. Buffers an
// application byte stream in a circular FIFO and presents it first-word-fall-
// through (registered head) on the in_* valid/ready port. Also produces the
// two flush hints the CPU firmware polls to decide when to close a USB IN
// packet: in_flush_now (a message end or an explicit flush is pending) and
// in_flush_time (buffered data has sat idle for TIMEOUT cycles).
//
// Build option:
//   ACM_IN_FEEDER_TIMER_EN - when defined, the 20-bit idle counter is built and
//                            drives in_flush_time. When undefined, in_flush_time
//                            is tied low and TIMEOUT has no effect.
//
// Parameters:
//   DEPTH_LOG2 - FIFO depth is 2**DEPTH_LOG2 entries of {last, data[7:0]}
//   TIMEOUT    - idle cycles before in_flush_time asserts (1 .. 2**20-1)
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   u_data/u_last   - user byte and end-of-message flag
//   u_valid/u_ready - user handshake; u_ready low only when the FIFO is full
//   u_flush         - single-cycle request to push buffered data out now
//   in_data/in_last - head-of-FIFO entry, stable while in_valid & ~in_ready
//   in_valid        - head entry present
//   in_ready        - downstream consumes the head entry
//   in_flush_now    - immediate-flush hint (registered)
//   in_flush_time   - idle-timeout flush hint (registered)
//   level           - FIFO occupancy, 0 .. 2**DEPTH_LOG2
// -----------------------------------------------------------------------------
module acm_in_feeder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            u_data,
    input  logic                  u_last,
    input  logic                  u_valid,
    output logic                  u_ready,
    input  logic                  u_flush,
    output logic [7:0]            in_data,
    output logic                  in_last,
    output logic                  in_valid,
    input  logic                  in_ready,
    output logic                  in_flush_now,
    output logic                  in_flush_time,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [8:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2:0]   lcnt_q, lcnt_d;
    logic [DEPTH_LOG2:0]   avail;
    logic                  head_valid_q, head_valid_d;
    logic                  head_last_q, head_last_d;
    logic [7:0]            head_data_q, head_data_d;
    logic                  freq_q, freq_d;
    logic                  flush_now_q, flush_now_d;
    logic                  push, pop, lcnt_inc, lcnt_dec;

    assign u_ready = (level_q != LVL_FULL);
    assign push    = u_valid & u_ready;
    assign pop     = head_valid_q & in_ready;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct in comb.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!push && pop) begin
            level_d = level_q - LVL_ONE;
        end

        // Entries already in memory that can feed the head this edge. A byte
        // pushed on this same edge is not readable yet, so it is excluded.
        avail = pop ? level_q - LVL_ONE : level_q;

        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_last_d  = head_last_q;
        if (!head_valid_q || pop) begin
            head_valid_d = (avail != '0);
            if (avail != '0) begin
                {head_last_d, head_data_d} = mem_q[rd_ptr_d];
            end
        end

        lcnt_inc = push & u_last;
        lcnt_dec = pop & head_last_q;
        lcnt_d   = lcnt_q;
        if (lcnt_inc && !lcnt_dec) begin
            lcnt_d = lcnt_q + LVL_ONE;
        end else if (!lcnt_inc && lcnt_dec) begin
            lcnt_d = lcnt_q - LVL_ONE;
        end

        // Clear when the FIFO drains; an accepted flush request wins.
        freq_d = freq_q;
        if (level_d == '0) begin
            freq_d = 1'b0;
        end
        if (u_flush && ((level_q != '0) || push)) begin
            freq_d = 1'b1;
        end

        flush_now_d = (lcnt_q != '0) | freq_q;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            lcnt_q       <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= 8'h00;
            head_last_q  <= 1'b0;
            freq_q       <= 1'b0;
            flush_now_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            lcnt_q       <= lcnt_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_last_q  <= head_last_d;
            freq_q       <= freq_d;
            flush_now_q  <= flush_now_d;
        end
    end

    // NOTE: the storage array has no reset; level/pointers guarantee a slot is
    // only read after it was written, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {u_last, u_data};
        end
    end

`ifdef ACM_IN_FEEDER_TIMER_EN
    localparam logic [19:0] TIMEOUT_V = 20'(TIMEOUT);

    logic [19:0] icnt_q, icnt_d;
    logic        flush_time_q, flush_time_d;

    always_comb begin
        icnt_d = icnt_q;
        if (push || (level_d == '0)) begin
            icnt_d = '0;
        end else if (icnt_q != TIMEOUT_V) begin
            icnt_d = icnt_q + 20'd1;
        end
        flush_time_d = (icnt_q == TIMEOUT_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt_q       <= '0;
            flush_time_q <= 1'b0;
        end else begin
            icnt_q       <= icnt_d;
            flush_time_q <= flush_time_d;
        end
    end

    assign in_flush_time = flush_time_q;
`else
    // TIMEOUT has no effect without the idle timer.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign in_flush_time  = 1'b0;
`endif

    assign in_data      = head_data_q;
    assign in_last      = head_last_q;
    assign in_valid     = head_valid_q;
    assign in_flush_now = flush_now_q;
    assign level        = level_q;

endmodule

// File: tb/tb_acm_in_feeder.sv
// -----------------------------------------------------------------------------
// tb_acm_in_feeder - self-checking bench for acm_in_feeder (DEPTH_LOG2 = 2,
// TIMEOUT = 10). A negedge monitor keeps a scoreboard queue: every accepted
// user byte is pushed, every consumed head entry is popped and compared.
// Scenario tasks check handshake, level, latency and flush hints inline.
// -----------------------------------------------------------------------------
module tb_acm_in_feeder;

    localparam int DL2 = 2;
    localparam int TO  = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [7:0]     u_data = 8'h00;
    logic           u_last = 1'b0;
    logic           u_valid = 1'b0;
    logic           u_ready;
    logic           u_flush = 1'b0;
    logic [7:0]     in_data;
    logic           in_last;
    logic           in_valid;
    logic           in_ready = 1'b0;
    logic           in_flush_now;
    logic           in_flush_time;
    logic [DL2:0]   level;

    int tests = 0;
    int fails = 0;
    int pops_seen = 0;
    logic [8:0] sb_q[$];
    logic [8:0] sb_exp;

    acm_in_feeder #(.DEPTH_LOG2(DL2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .u_data(u_data), .u_last(u_last), .u_valid(u_valid), .u_ready(u_ready),
        .u_flush(u_flush),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .in_flush_now(in_flush_now), .in_flush_time(in_flush_time), .level(level)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: inputs change 1 time unit after posedge, so the
    // values seen at negedge are exactly those sampled at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                pops_seen++;
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_pop: got data=%h last=%b, expected nothing (queue empty)", in_data, in_last);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if ({in_last, in_data} !== sb_exp) begin
                        fails++;
                        $display("FAIL sb_pop: got data=%h last=%b, expected data=%h last=%b",
                                 in_data, in_last, sb_exp[7:0], sb_exp[8]);
                    end
                end
            end
            if (u_valid && u_ready) sb_q.push_back({u_last, u_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_valid = 1'b0; u_last = 1'b0; u_flush = 1'b0; in_ready = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        u_valid = 1'b0;
        in_ready = 1'b1;
        while (level != '0 && n < 100) begin
            cyc();
            n++;
        end
        in_ready = 1'b0;
        cyc();
        tests++;
        if (level !== '0 || in_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain: got level=%0d in_valid=%b, expected level=0 in_valid=0", level, in_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if ({u_ready, in_valid, in_data, in_last, in_flush_now, in_flush_time, level} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset_values: got rdy=%b v=%b d=%h l=%b fn=%b ft=%b lvl=%0d, expected 1 0 00 0 0 0 0",
                     u_ready, in_valid, in_data, in_last, in_flush_now, in_flush_time, level);
        end
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        idle_inputs();
        u_valid = 1'b1; u_data = 8'h11; cyc();
        tests++;
        if (in_valid !== 1'b0 || level !== 3'd1) begin
            fails++;
            $display("FAIL basic_latency: got in_valid=%b level=%0d, expected 0 and 1", in_valid, level);
        end
        u_data = 8'h22; cyc();
        u_data = 8'h33; cyc();
        u_valid = 1'b0;
        tests++;
        if (level !== 3'd3 || in_valid !== 1'b1 || in_data !== 8'h11) begin
            fails++;
            $display("FAIL basic_fill: got level=%0d v=%b d=%h, expected 3 1 11", level, in_valid, in_data);
        end
        in_ready = 1'b1; cyc();
        tests++;
        if (in_valid !== 1'b1 || in_data !== 8'h22) begin
            fails++;
            $display("FAIL basic_b2b: got v=%b d=%h, expected 1 22", in_valid, in_data);
        end
        cyc(); cyc();
        in_ready = 1'b0;
        tests++;
        if (in_valid !== 1'b0 || level !== 3'd0) begin
            fails++;
            $display("FAIL basic_empty: got v=%b level=%0d, expected 0 0", in_valid, level);
        end
        cyc();
    endtask

    task automatic test_full_wrap();
        int sent = 0;
        int n = 0;
        int base;
        idle_inputs();
        u_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            u_data = 8'h40 + 8'(k);
            cyc();
        end
        tests++;
        if (u_ready !== 1'b0 || level !== 3'd4) begin
            fails++;
            $display("FAIL full_state: got u_ready=%b level=%0d, expected 0 4", u_ready, level);
        end
        u_data = 8'h44; cyc();
        tests++;
        if (level !== 3'd4) begin
            fails++;
            $display("FAIL full_hold: got level=%0d, expected 4", level);
        end
        in_ready = 1'b1; cyc();
        in_ready = 1'b0;
        tests++;
        if (u_ready !== 1'b1 || level !== 3'd3) begin
            fails++;
            $display("FAIL full_pop1: got u_ready=%b level=%0d, expected 1 3", u_ready, level);
        end
        cyc();
        u_valid = 1'b0;
        tests++;
        if (level !== 3'd4 || u_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_accept5: got level=%0d u_ready=%b, expected 4 0", level, u_ready);
        end
        base = pops_seen;
        while ((sent < 200 || level != '0) && n < 5000) begin
            u_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            u_data   = 8'($urandom);
            u_last   = 1'($urandom_range(0, 1));
            in_ready = ($urandom_range(0, 3) != 0);
            if (u_valid && u_ready) sent++;
            cyc();
            n++;
        end
        idle_inputs();
        cyc();
        tests++;
        if (pops_seen - base !== 204 || sb_q.size() !== 0 || n >= 5000) begin
            fails++;
            $display("FAIL wrap_stream: got pops=%0d left=%0d cycles=%0d, expected pops=204 left=0 cycles<5000",
                     pops_seen - base, sb_q.size(), n);
        end
        cyc(); cyc();
    endtask

    task automatic test_flush_last();
        idle_inputs();
        u_valid = 1'b1; u_data = 8'hA0; u_last = 1'b1; cyc();
        u_valid = 1'b0; u_last = 1'b0;
        tests++;
        if (in_flush_now !== 1'b0) begin
            fails++; $display("FAIL last_pre: got flush_now=%b, expected 0", in_flush_now);
        end
        cyc();
        tests++;
        if (in_flush_now !== 1'b1) begin
            fails++; $display("FAIL last_rise: got flush_now=%b, expected 1", in_flush_now);
        end
        in_ready = 1'b1; cyc();
        in_ready = 1'b0;
        tests++;
        if (in_flush_now !== 1'b1) begin
            fails++; $display("FAIL last_hold: got flush_now=%b, expected 1", in_flush_now);
        end
        cyc();
        tests++;
        if (in_flush_now !== 1'b0) begin
            fails++; $display("FAIL last_fall: got flush_now=%b, expected 0", in_flush_now);
        end
        // Same-edge pop of one last byte and push of another keeps lcnt at 1.
        u_valid = 1'b1; u_data = 8'hB1; u_last = 1'b1; cyc();
        u_valid = 1'b0; cyc();
        in_ready = 1'b1; u_valid = 1'b1; u_data = 8'hB2; u_last = 1'b1; cyc();
        idle_inputs(); cyc(); cyc();
        tests++;
        if (in_flush_now !== 1'b1 || in_data !== 8'hB2 || in_last !== 1'b1) begin
            fails++;
            $display("FAIL last_same_edge: got fn=%b d=%h l=%b, expected 1 b2 1", in_flush_now, in_data, in_last);
        end
        in_ready = 1'b1; cyc();
        in_ready = 1'b0; cyc();
        tests++;
        if (in_flush_now !== 1'b0) begin
            fails++; $display("FAIL last_same_clear: got flush_now=%b, expected 0", in_flush_now);
        end
    endtask

    task automatic test_flush_req();
        idle_inputs();
        u_valid = 1'b1; u_data = 8'h66; cyc();
        u_valid = 1'b0; cyc();
        u_flush = 1'b1; cyc();
        u_flush = 1'b0;
        tests++;
        if (in_flush_now !== 1'b0) begin
            fails++; $display("FAIL freq_pre: got flush_now=%b, expected 0", in_flush_now);
        end
        cyc(); cyc(); cyc();
        tests++;
        if (in_flush_now !== 1'b1) begin
            fails++; $display("FAIL freq_held: got flush_now=%b, expected 1", in_flush_now);
        end
        in_ready = 1'b1; cyc();
        in_ready = 1'b0; cyc();
        tests++;
        if (in_flush_now !== 1'b0) begin
            fails++; $display("FAIL freq_clear: got flush_now=%b, expected 0", in_flush_now);
        end
        u_flush = 1'b1; cyc();
        u_flush = 1'b0; cyc(); cyc();
        tests++;
        if (in_flush_now !== 1'b0) begin
            fails++; $display("FAIL freq_empty: got flush_now=%b, expected 0", in_flush_now);
        end
    endtask

    task automatic test_timer();
        logic exp_t;
        logic exp_hi;
`ifdef ACM_IN_FEEDER_TIMER_EN
        exp_hi = 1'b1;
`else
        exp_hi = 1'b0;
`endif
        idle_inputs();
        u_valid = 1'b1; u_data = 8'h77; cyc();
        u_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            u_valid = (k == 5);
            u_data  = 8'h78;
            cyc();
            u_valid = 1'b0;
            exp_t = exp_hi & (k >= 16);
            tests++;
            if (in_flush_time !== exp_t) begin
                fails++;
                $display("FAIL timer_k%0d: got flush_time=%b, expected %b", k, in_flush_time, exp_t);
            end
        end
        u_valid = 1'b1; u_data = 8'h79; cyc();
        u_valid = 1'b0;
        tests++;
        if (in_flush_time !== exp_hi) begin
            fails++; $display("FAIL timer_push_edge: got flush_time=%b, expected %b", in_flush_time, exp_hi);
        end
        cyc();
        tests++;
        if (in_flush_time !== 1'b0) begin
            fails++; $display("FAIL timer_push_fall: got flush_time=%b, expected 0", in_flush_time);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        u_valid = 1'b1; u_data = 8'h91; cyc();
        u_data = 8'h92; cyc();
        u_data = 8'h93; u_last = 1'b1; cyc();
        idle_inputs(); cyc(); cyc();
        tests++;
        if (level !== 3'd3 || in_flush_now !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre: got level=%0d fn=%b, expected 3 1", level, in_flush_now);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({u_ready, in_valid, in_data, in_last, in_flush_now, in_flush_time, level} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL rstmid_async: got rdy=%b v=%b d=%h l=%b fn=%b ft=%b lvl=%0d, expected 1 0 00 0 0 0 0",
                     u_ready, in_valid, in_data, in_last, in_flush_now, in_flush_time, level);
        end
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        u_valid = 1'b1; u_data = 8'h55; cyc();
        u_valid = 1'b0; cyc();
        tests++;
        if (in_valid !== 1'b1 || in_data !== 8'h55 || in_last !== 1'b0 || level !== 3'd1 || in_flush_now !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_after: got v=%b d=%h l=%b lvl=%0d fn=%b, expected 1 55 0 1 0",
                     in_valid, in_data, in_last, level, in_flush_now);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_flush_last();
        test_flush_req();
        test_timer();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
